// File: rtl/cfg_frame_sequencer.sv
// Configuration frame sequencer: accepts a header (sync, start index, count),
// then writes each following word to FrameData and fires one frame strobe per word.
module cfg_frame_sequencer #(
    parameter int unsigned FRAME_BITS = 32,
    parameter int unsigned NUM_FRAMES = 20
) (
    input  logic                  CLK,
    input  logic                  resetn,
    input  logic [FRAME_BITS-1:0] s_data,
    input  logic                  s_valid,
    output logic                  s_ready,
    output logic [FRAME_BITS-1:0] FrameData,
    output logic [NUM_FRAMES-1:0] FrameStrobe,
    output logic                  busy,
    output logic                  done,
    output logic                  error
);

    localparam int unsigned IDX_W = 9;
    localparam int unsigned CNT_W = 8;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        LOAD   = 2'd1,
        STROBE = 2'd2,
        HOLD   = 2'd3
    } state_t;

    state_t                state, state_d;
    logic [IDX_W-1:0]      index, index_d;
    logic [CNT_W-1:0]      count, count_d;
    logic [FRAME_BITS-1:0] data_d;
    logic [NUM_FRAMES-1:0] strobe_d;
    logic                  ready_d, busy_d, done_d, error_d;

    logic [7:0]       hdr_sync, hdr_start, hdr_count;
    logic [IDX_W-1:0] hdr_end;
    logic             hdr_ok;
    logic             xfer;

    // Header decode; end index computed one bit wider so S+N cannot wrap
    assign hdr_sync  = s_data[31:24];
    assign hdr_start = s_data[15:8];
    assign hdr_count = s_data[7:0];
    assign hdr_end   = IDX_W'(hdr_start) + IDX_W'(hdr_count);
    assign hdr_ok    = (hdr_sync == 8'hA5) && (hdr_count != 8'd0)
                       && (hdr_end <= IDX_W'(NUM_FRAMES));
    assign xfer      = s_valid && s_ready;

    // Next-state and next-output logic
    always_comb begin
        state_d  = state;
        index_d  = index;
        count_d  = count;
        data_d   = FrameData;
        strobe_d = '0;
        done_d   = 1'b0;
        error_d  = 1'b0;

        case (state)
            IDLE: begin
                if (xfer) begin
                    if (hdr_ok) begin
                        index_d = IDX_W'(hdr_start);
                        count_d = hdr_count;
                        state_d = LOAD;
                    end else begin
                        error_d = 1'b1;
                    end
                end
            end
            LOAD: begin
                if (xfer) begin
                    data_d  = s_data;
                    state_d = STROBE;
                    for (int unsigned i = 0; i < NUM_FRAMES; i++) begin
                        strobe_d[i] = (index == IDX_W'(i));
                    end
                end
            end
            STROBE: begin
                state_d = HOLD;
            end
            HOLD: begin
                index_d = index + IDX_W'(1);
                count_d = count - CNT_W'(1);
                if (count > CNT_W'(1)) begin
                    state_d = LOAD;
                end else begin
                    state_d = IDLE;
                    done_d  = 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase

        ready_d = (state_d == IDLE) || (state_d == LOAD);
        busy_d  = (state_d != IDLE);
    end

    // State and registered outputs
    always_ff @(posedge CLK or negedge resetn) begin
        if (!resetn) begin
            state       <= IDLE;
            index       <= '0;
            count       <= '0;
            FrameData   <= '0;
            FrameStrobe <= '0;
            s_ready     <= 1'b0;
            busy        <= 1'b0;
            done        <= 1'b0;
            error       <= 1'b0;
        end else begin
            state       <= state_d;
            index       <= index_d;
            count       <= count_d;
            FrameData   <= data_d;
            FrameStrobe <= strobe_d;
            s_ready     <= ready_d;
            busy        <= busy_d;
            done        <= done_d;
            error       <= error_d;
        end
    end

endmodule
